// File: rtl/uart_sbm_pkg.sv
// Shared constants and state encodings for the UART-to-simple-bus master.
// Optional timeout (UART_SBM_TIMEOUT_EN) lives in the top module.
package uart_sbm_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_ERR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sbm_phy.sv
// Serial bit engines: 2-flop input synchronizer, 8N1 receiver and transmitter.
// tx_busy drops in the final stop-bit cycle so a new byte can follow with no gap.
module uart_sbm_phy
  import uart_sbm_pkg::*;
#(
  parameter logic [15:0] DIV = 16'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam logic [15:0] LAST = DIV - 16'd1;
  localparam logic [15:0] HALF = (DIV >> 1) - 16'd1;

  logic      rx_s1, rx_s2, rx_prev;
  rx_state_t rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_tick;

  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // The start bit is checked half a bit in, every later sample lands mid-bit.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF) : (rx_cnt == LAST);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      // A low stop bit drops the byte without any indication upstream.
      if (rx_state == RX_STOP && rx_tick && rx_s2) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
      end
    end
  end

  assign tx_busy = tx_act && !(tx_bit == 4'd9 && tx_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx <= 1'b1;
      tx_act  <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
    end else if (tx_start && !tx_busy) begin
      uart_tx <= 1'b0;
      tx_sh   <= tx_data;
      tx_act  <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_act) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_act <= 1'b0;
          tx_bit <= '0;
        end else begin
          uart_tx <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[7:1]};
          tx_bit  <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_sbm.sv
// UART command-frame decoder driving the simple register bus as initiator.
// Define UART_SBM_TIMEOUT_EN to abort partial frames after TO_BYTES idle byte times.
module uart_sbm
  import uart_sbm_pkg::*;
#(
  parameter logic [15:0] DIV      = 16'd50,
  parameter int unsigned TO_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [4:0]  addr,
  output logic        re,
  output logic        we,
  output logic [31:0] wd,
  input  logic [31:0] rd,
  output logic        busy
);

  if (DIV < 16'd4 || TO_BYTES == 0) begin : g_bad_cfg
    $error("uart_sbm: DIV must be at least 4 and TO_BYTES at least 1");
  end

  state_t      state, next_state;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_start, tx_busy;
  logic [4:0]  addr_q;
  logic [31:0] data_sh, resp_sh;
  logic [1:0]  byte_cnt, resp_left;
  logic        is_wr;
  logic        to_expired;

  uart_sbm_phy #(.DIV(DIV)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

`ifdef UART_SBM_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(DIV) * 32'd10 * 32'(TO_BYTES);
  logic [31:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) to_cnt <= '0;
    else if ((state == S_ADDR || state == S_DATA) && !rx_valid) to_cnt <= to_cnt + 32'd1;
    else to_cnt <= '0;
  end

  assign to_expired = (state == S_ADDR || state == S_DATA) && !rx_valid &&
                      (to_cnt == TO_LIM - 32'd1);
`else
  assign to_expired = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    next_state = state;
    re         = 1'b0;
    we         = 1'b0;
    tx_start   = 1'b0;
    tx_data    = resp_sh[7:0];
    case (state)
      S_IDLE: if (rx_valid) next_state = (rx_data == CMD_WR || rx_data == CMD_RD) ? S_ADDR : S_ERR;
      S_ADDR: begin
        if (to_expired) next_state = S_ERR;
        else if (rx_valid) next_state = is_wr ? S_DATA : S_BUS_RD;
      end
      S_DATA: begin
        if (to_expired) next_state = S_ERR;
        else if (rx_valid && byte_cnt == 2'd3) next_state = S_BUS_WR;
      end
      S_BUS_WR: begin
        we         = 1'b1;
        tx_start   = 1'b1;
        tx_data    = RSP_OK;
        next_state = S_RESP;
      end
      S_BUS_RD: begin
        re         = 1'b1;
        tx_start   = 1'b1;
        tx_data    = rd[7:0];
        next_state = S_RESP;
      end
      S_ERR: begin
        tx_start   = 1'b1;
        tx_data    = RSP_ERR;
        next_state = S_RESP;
      end
      S_RESP: begin
        if (!tx_busy) begin
          if (resp_left != 2'd0) tx_start = 1'b1;
          else next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // addr/wd only change when a bus access is about to happen, so aborted frames leave them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      wd        <= '0;
      addr_q    <= '0;
      data_sh   <= '0;
      byte_cnt  <= '0;
      is_wr     <= 1'b0;
      resp_sh   <= '0;
      resp_left <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            is_wr    <= (rx_data == CMD_WR);
            byte_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data[4:0];
            if (!is_wr) addr <= rx_data[4:0];
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_sh  <= {rx_data, data_sh[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wd   <= {rx_data, data_sh[31:8]};
              addr <= addr_q;
            end
          end
        end
        S_BUS_RD: begin
          resp_sh   <= {8'h00, rd[31:8]};
          resp_left <= 2'd3;
        end
        S_BUS_WR, S_ERR: resp_left <= 2'd0;
        S_RESP: begin
          if (tx_start) begin
            resp_sh   <= {8'h00, resp_sh[31:8]};
            resp_left <= resp_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sbm.sv
// Scoreboard bench for uart_sbm: bus and serial-response monitors pop expectations
// queued by the directed stimulus sequence.
module tb_uart_sbm;

  localparam int D = 16;
  localparam logic [15:0] DIV = 16'(D);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [4:0]  addr;
  logic        re, we, busy;
  logic [31:0] wd, rd;

  typedef struct {
    logic [7:0] b;
    bit         lat;
    bit         b2b;
  } rsp_t;

  typedef struct {
    bit          is_wr;
    logic [4:0]  a;
    logic [31:0] d;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_bus_cyc = -1000;

  uart_sbm #(.DIV(DIV), .TO_BYTES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .addr    (addr),
    .re      (re),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: one fixed word at 0x10, a tagged address echo elsewhere.
  assign rd = (addr == 5'h10) ? 32'hCAFEF00D : {24'hA5A5A5, 3'b000, addr};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [7:0] b, input bit lat, input bit b2b);
    rsp_t e;
    e.b = b; e.lat = lat; e.b2b = b2b;
    rsp_q.push_back(e);
  endtask

  task automatic expect_bus(input bit is_wr, input logic [4:0] a, input logic [31:0] d);
    bus_t e;
    e.is_wr = is_wr; e.a = a; e.d = d;
    bus_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (D) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_rsp_done"}, rsp_q.size(), 0);
    checkOutput({name, "_busy_in_stop"}, busy, 1'b1);
    n = 0;
    while (busy && n < 4 * D) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, busy, 1'b0);
    checkOutput({name, "_bus_done"}, bus_q.size(), 0);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    checkOutput({name, "_uart_tx"}, uart_tx, 1'b1);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_addr"}, addr, 5'h00);
    checkOutput({name, "_wd"}, wd, 32'h0);
    checkOutput({name, "_re_we"}, {re, we}, 2'b00);
    rst = 1'b0;
    repeat (4 * D) @(negedge clk);
  endtask

  // Bus monitor: every re/we pulse must match the next queued access.
  initial begin : bus_mon
    bus_t e;
    forever begin
      @(negedge clk);
      if (!rst && (re || we)) begin
        last_bus_cyc = cyc;
        checkOutput("re_we_exclusive", re & we, 1'b0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL bus_unexpected: got re=%0b we=%0b addr=0x%0h, expected no access", re, we, addr);
        end else begin
          e = bus_q.pop_front();
          checkOutput("bus_kind_we", we, e.is_wr);
          checkOutput("bus_addr", addr, e.a);
          if (e.is_wr) checkOutput("bus_wd", wd, e.d);
        end
      end
    end
  end

  // Serial monitor: decodes uart_tx mid-bit and checks byte, latency and spacing.
  initial begin : tx_mon
    rsp_t e;
    logic [7:0] b;
    int start_cyc;
    int last_start;
    last_start = -100000;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        start_cyc = cyc;
        repeat (D / 2) @(negedge clk);
        checkOutput("tx_start_bit", uart_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (D) @(negedge clk);
        checkOutput("tx_stop_bit", uart_tx, 1'b1);
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte", b);
        end else begin
          e = rsp_q.pop_front();
          checkOutput("tx_byte", b, e.b);
          if (e.lat) checkOutput("rsp_latency", start_cyc - last_bus_cyc, 1);
          if (e.b2b) checkOutput("tx_b2b_spacing", start_cyc - last_start, 10 * D);
        end
        last_start = start_cyc;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    checkOutput("rst_uart_tx", uart_tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_re_we", {re, we}, 2'b00);
    checkOutput("rst_addr", addr, 5'h00);
    checkOutput("rst_wd", wd, 32'h0);
    rst = 1'b0;
    repeat (4 * D) @(negedge clk);

    $display("[TB] write 0x12345678 to 0x0C");
    expect_bus(1'b1, 5'h0C, 32'h12345678);
    expect_rsp(8'h4B, 1'b1, 1'b0);
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h0C, 1'b1);
    applyStimulus(8'h78, 1'b1);
    applyStimulus(8'h56, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    wait_drain("write", 20 * D);

    $display("[TB] read 0x10 via address byte 0xF0");
    expect_bus(1'b0, 5'h10, 32'h0);
    expect_rsp(8'h0D, 1'b1, 1'b0);
    expect_rsp(8'hF0, 1'b0, 1'b1);
    expect_rsp(8'hFE, 1'b0, 1'b1);
    expect_rsp(8'hCA, 1'b0, 1'b1);
    applyStimulus(8'h52, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    wait_drain("read10", 50 * D);

    $display("[TB] read 0x05 via address byte 0x25");
    expect_bus(1'b0, 5'h05, 32'h0);
    expect_rsp(8'h05, 1'b1, 1'b0);
    expect_rsp(8'hA5, 1'b0, 1'b1);
    expect_rsp(8'hA5, 1'b0, 1'b1);
    expect_rsp(8'hA5, 1'b0, 1'b1);
    applyStimulus(8'h52, 1'b1);
    applyStimulus(8'h25, 1'b1);
    wait_drain("read05", 50 * D);

    $display("[TB] unknown command 0x33");
    expect_rsp(8'h45, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b1);
    wait_drain("unknown", 20 * D);

    $display("[TB] framing error on command byte, then a valid write");
    applyStimulus(8'h57, 1'b0);
    repeat (4 * D) @(negedge clk);
    checkOutput("framing_still_idle", busy, 1'b0);
    expect_bus(1'b1, 5'h03, 32'hDDCCBBAA);
    expect_rsp(8'h4B, 1'b1, 1'b0);
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hBB, 1'b1);
    applyStimulus(8'hCC, 1'b1);
    applyStimulus(8'hDD, 1'b1);
    wait_drain("write2", 20 * D);
    checkOutput("addr_hold", addr, 5'h03);
    checkOutput("wd_hold", wd, 32'hDDCCBBAA);

    $display("[TB] partial frame then silence");
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h00, 1'b1);
`ifdef UART_SBM_TIMEOUT_EN
    expect_rsp(8'h45, 1'b0, 1'b0);
    wait_drain("timeout", 60 * D);
`else
    repeat (60 * D) @(negedge clk);
    checkOutput("no_timeout_busy", busy, 1'b1);
    checkOutput("no_timeout_rsp", rsp_q.size(), 0);
    pulse_reset("recover");
`endif

    $display("[TB] reset during third data byte");
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (i == 1);
      repeat (D) @(negedge clk);
    end
    checkOutput("midframe_busy", busy, 1'b1);
    pulse_reset("midframe_rst");

    $display("[TB] read after reset");
    expect_bus(1'b0, 5'h10, 32'h0);
    expect_rsp(8'h0D, 1'b1, 1'b0);
    expect_rsp(8'hF0, 1'b0, 1'b1);
    expect_rsp(8'hFE, 1'b0, 1'b1);
    expect_rsp(8'hCA, 1'b0, 1'b1);
    applyStimulus(8'h52, 1'b1);
    applyStimulus(8'h10, 1'b1);
    wait_drain("read_after_rst", 50 * D);

    repeat (4 * D) @(negedge clk);
    checkOutput("final_rsp_queue", rsp_q.size(), 0);
    checkOutput("final_bus_queue", bus_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
